mdu_ctrl: RTL and testbench
===========================

# mdu_ctrl

Parametrised multiply/divide unit with its own issue control for the pipelined MIPS core. Sits in the E stage beside the ALU. It accepts mult/multu/div/divu/mthi/mtlo, holds the HI/LO registers, and models multi-cycle latency with a busy counter. It generates the stall request that the hazard logic uses to hold an MDU-class instruction in D.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1).
- DIV_CYCLES, 10, busy cycles for div/divu (≥1).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  E-stage instruction is an MDU op this cycle (one-cycle pulse per instruction).
- op  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 reserved (no effect).
- a  in  WIDTH  forwarded rs value.
- b  in  WIDTH  forwarded rt value.
- d_is_mdu  in  1  D-stage instruction is any of mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- hi  out  WIDTH  architectural HI (mfhi data).
- lo  out  WIDTH  architectural LO (mflo data).
- busy  out  1  arithmetic operation in flight.
- stall_req  out  1  hold D-stage MDU instruction.

## Operation
- State: hi_r, lo_r, busy counter cnt (width clog2(max(MULT_CYCLES,DIV_CYCLES)+1)), result buffers res_hi/res_lo, and a pending-op latch.
- Accept rule: start is honoured only when cnt==0. start while busy is ignored; it cannot occur in a legal pipeline because of stall_req.
- mult/multu: the full 2·WIDTH product of a and b (signed or unsigned) is computed at accept and buffered. HI gets the upper WIDTH bits and LO the lower WIDTH bits. cnt is loaded with MULT_CYCLES.
- div/divu: the quotient is buffered for LO and the remainder for HI. cnt is loaded with DIV_CYCLES.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - Overflow case −2^(WIDTH−1) / −1: LO = 0x80000000, HI = 0.
  - Divide by zero: busy runs the full DIV_CYCLES, then HI/LO stay unchanged (no write).
- mthi/mtlo: hi_r←a or lo_r←a at the accept edge. No busy and cnt is untouched.
- Commit: on the edge where cnt goes 1→0, hi_r/lo_r are loaded from the buffers, unless the op was a divide by zero.
- busy = (cnt != 0).
- stall_req = d_is_mdu & (busy | (start & op≤3)). It is combinational.
- hi/lo outputs are registered values, never the buffers. mfhi therefore only reads committed data.
- Reserved op: start is accepted with no state change.

## Timing
- Reset (async): hi=0, lo=0, busy=0, stall_req=d_is_mdu&start&op≤3 (combinational), cnt=0, pending dropped. Reset mid-operation discards the result.
- Accept at edge T with latency N:
  - busy is high in cycles T+1 … T+N.
  - hi/lo show the new value from edge T+N onward.
  - busy is low in that same cycle.
- Back-to-back: a start in the cycle busy is low (after commit) is accepted at once, so there are no dead cycles.
- mthi/mtlo: the new value is visible on hi/lo the cycle after the accept edge.
- While busy, hi/lo hold their old values.
- mthi/mtlo cannot arrive while busy because stall_req holds them in D.
- Latency is exactly N regardless of operand values, including zero or negative operands.
- stall_req is asserted in the start cycle of a mult/div when d_is_mdu=1. This covers a dependent mfhi directly behind the op.

## Test plan
- mult a=0xFFFFFFFF, b=2 (MULT_CYCLES=5) → busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE. The same operands with multu → hi=0x00000001, lo=0xFFFFFFFE.
- div a=−7 (0xFFFFFFF9), b=2 → after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=7, b=2 → lo=3, hi=1.
- div a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0. Next, div by b=0 with hi=0x11, lo=0x22 preset via mthi/mtlo → busy 10 cycles, then hi/lo remain 0x11/0x22.
- mult in flight with d_is_mdu=1 → stall_req=1 in the start cycle and every busy cycle, 0 in the cycle after commit. With d_is_mdu=0, stall_req=0 throughout.
- Assert reset 2 cycles into a div → busy=0, hi=lo=0 immediately. No commit occurs at the former T+10.
- Parameter sweep with MULT_CYCLES=1, DIV_CYCLES=1 → busy high exactly one cycle. Back-to-back mult then mtlo → lo reflects the mtlo value, hi keeps the mult result.

Source files
------------

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit for the E stage: holds HI/LO, models multi-cycle latency
// with a down-counter, and raises the stall request that holds MDU ops in D.
module mdu_ctrl #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             d_is_mdu,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall_req
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  // Full-width product; signed operands are sign-extended so the low 2*WIDTH bits are exact.
  function automatic logic [2*WIDTH-1:0] mul_full(input logic [WIDTH-1:0] x,
                                                   input logic [WIDTH-1:0] y,
                                                   input logic             sgn);
    logic [2*WIDTH-1:0] xe;
    logic [2*WIDTH-1:0] ye;
    xe = {{WIDTH{sgn & x[WIDTH-1]}}, x};
    ye = {{WIDTH{sgn & y[WIDTH-1]}}, y};
    return xe * ye;
  endfunction

  // Returns {remainder, quotient}; magnitude division makes MIN/-1 wrap to MIN with remainder 0.
  function automatic logic [2*WIDTH-1:0] div_full(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y,
                                                  input logic             sgn);
    logic             neg_x;
    logic             neg_y;
    logic [WIDTH-1:0] ux;
    logic [WIDTH-1:0] uy;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    neg_x = sgn & x[WIDTH-1];
    neg_y = sgn & y[WIDTH-1];
    ux    = neg_x ? -x : x;
    uy    = neg_y ? -y : y;
    if (uy == {WIDTH{1'b0}}) begin
      q = {WIDTH{1'b0}};
      r = {WIDTH{1'b0}};
    end else begin
      q = ux / uy;
      r = ux % uy;
    end
    if (neg_x ^ neg_y) begin
      q = -q;
    end else begin
      q = q;
    end
    if (neg_x) begin
      r = -r;
    end else begin
      r = r;
    end
    return {r, q};
  endfunction

  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic [WIDTH-1:0]   res_hi_r;
  logic [WIDTH-1:0]   res_lo_r;
  logic [CW-1:0]      cnt_r;
  logic               pend_wr_r;
  logic [2*WIDTH-1:0] res_s;
  logic               idle_s;

  assign idle_s = (cnt_r == CNT_ZERO);

  // Result of the op presented this cycle, laid out as {hi, lo}.
  always_comb begin
    res_s = {2*WIDTH{1'b0}};
    case (op)
      OP_MULT:  res_s = mul_full(a, b, 1'b1);
      OP_MULTU: res_s = mul_full(a, b, 1'b0);
      OP_DIV:   res_s = div_full(a, b, 1'b1);
      OP_DIVU:  res_s = div_full(a, b, 1'b0);
      default:  res_s = {2*WIDTH{1'b0}};
    endcase
  end

  // Accept, count down and commit; moves to HI/LO bypass the counter entirely.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
      res_hi_r  <= {WIDTH{1'b0}};
      res_lo_r  <= {WIDTH{1'b0}};
      cnt_r     <= CNT_ZERO;
      pend_wr_r <= 1'b0;
    end else if (idle_s) begin
      if (start) begin
        case (op)
          OP_MULT, OP_MULTU: begin
            res_hi_r  <= res_s[2*WIDTH-1:WIDTH];
            res_lo_r  <= res_s[WIDTH-1:0];
            cnt_r     <= MULT_LD;
            pend_wr_r <= 1'b1;
          end
          OP_DIV, OP_DIVU: begin
            res_hi_r  <= res_s[2*WIDTH-1:WIDTH];
            res_lo_r  <= res_s[WIDTH-1:0];
            cnt_r     <= DIV_LD;
            // A zero divisor still takes the full latency but never writes back.
            pend_wr_r <= (b != {WIDTH{1'b0}});
          end
          OP_MTHI: hi_r <= a;
          OP_MTLO: lo_r <= a;
          default: ;
        endcase
      end
    end else begin
      cnt_r <= cnt_r - CNT_ONE;
      if ((cnt_r == CNT_ONE) && pend_wr_r) begin
        hi_r <= res_hi_r;
        lo_r <= res_lo_r;
      end
    end
  end

  assign hi        = hi_r;
  assign lo        = lo_r;
  assign busy      = ~idle_s;
  assign stall_req = d_is_mdu & (busy | (start & ~op[2]));

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: default latencies on u0, single-cycle latencies on u1.
module tb_mdu_ctrl;

  logic        clk;
  logic        reset;
  logic        start0;
  logic        start1;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        d_is_mdu;
  logic [31:0] hi0, lo0, hi1, lo1;
  logic        busy0, busy1, stall0, stall1;
  logic        sel;

  int n_cmp = 0;
  int n_err = 0;

  mdu_ctrl #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) u0 (
    .clk(clk), .reset(reset), .start(start0), .op(op), .a(a), .b(b),
    .d_is_mdu(d_is_mdu), .hi(hi0), .lo(lo0), .busy(busy0), .stall_req(stall0)
  );

  mdu_ctrl #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(1)) u1 (
    .clk(clk), .reset(reset), .start(start1), .op(op), .a(a), .b(b),
    .d_is_mdu(d_is_mdu), .hi(hi1), .lo(lo1), .busy(busy1), .stall_req(stall1)
  );

  wire [31:0] hi_v    = sel ? hi1 : hi0;
  wire [31:0] lo_v    = sel ? lo1 : lo0;
  wire        busy_v  = sel ? busy1 : busy0;
  wire        stall_v = sel ? stall1 : stall0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op, count busy cycles, then check latency, HI/LO and stall.
  task automatic run_op(input logic s, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int lat,
                        input logic [31:0] ehi, input logic [31:0] elo, input string tag);
    logic [31:0] ohi, olo;
    int n;
    sel = s;
    #0;
    ohi = hi_v;
    olo = lo_v;
    op = o; a = x; b = y;
    if (s) start1 = 1'b1; else start0 = 1'b1;
    #1;
    check({tag, "_stall_start"}, {63'd0, stall_v}, {63'd0, d_is_mdu & (o <= 3'd3)});
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
    n = 0;
    while (busy_v && n < 50) begin
      n++;
      check({tag, "_hold_hi"}, {32'd0, hi_v}, {32'd0, ohi});
      check({tag, "_hold_lo"}, {32'd0, lo_v}, {32'd0, olo});
      check({tag, "_stall_busy"}, {63'd0, stall_v}, {63'd0, d_is_mdu});
      @(posedge clk); #1;
    end
    check({tag, "_latency"}, 64'(n), 64'(lat));
    check({tag, "_hi"}, {32'd0, hi_v}, {32'd0, ehi});
    check({tag, "_lo"}, {32'd0, lo_v}, {32'd0, elo});
    check({tag, "_stall_after"}, {63'd0, stall_v}, 64'd0);
  endtask

  initial begin
    clk = 1'b0; reset = 1'b1; start0 = 1'b0; start1 = 1'b0;
    op = 3'd0; a = 32'd0; b = 32'd0; d_is_mdu = 1'b0; sel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", {32'd0, hi0}, 64'd0);
    check("rst_lo", {32'd0, lo0}, 64'd0);
    check("rst_busy", {63'd0, busy0}, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_stall", {63'd0, stall0}, 64'd0);

    d_is_mdu = 1'b1;
    run_op(1'b0, 3'd0, 32'hFFFFFFFF, 32'd2, 5, 32'hFFFFFFFF, 32'hFFFFFFFE, "mult");
    d_is_mdu = 1'b0;
    run_op(1'b0, 3'd1, 32'hFFFFFFFF, 32'd2, 5, 32'h00000001, 32'hFFFFFFFE, "multu");
    run_op(1'b0, 3'd2, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg");
    run_op(1'b0, 3'd3, 32'd7, 32'd2, 10, 32'd1, 32'd3, "divu");
    run_op(1'b0, 3'd2, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000, "div_ovf");
    d_is_mdu = 1'b1;
    run_op(1'b0, 3'd4, 32'h11, 32'd0, 0, 32'h11, 32'h80000000, "mthi");
    run_op(1'b0, 3'd5, 32'h22, 32'd0, 0, 32'h11, 32'h22, "mtlo");
    run_op(1'b0, 3'd2, 32'd5, 32'd0, 10, 32'h11, 32'h22, "div_zero");
    run_op(1'b0, 3'd6, 32'h99, 32'h99, 0, 32'h11, 32'h22, "reserved");
    d_is_mdu = 1'b0;
    run_op(1'b0, 3'd0, 32'd3, 32'd4, 5, 32'd0, 32'd12, "mult_small");
    run_op(1'b0, 3'd3, 32'd100, 32'd7, 10, 32'd2, 32'd14, "b2b_divu");

    // Reset two cycles into a divide discards the result.
    sel = 1'b0;
    op = 3'd3; a = 32'd50; b = 32'd3;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("rstmid_busy", {63'd0, busy0}, 64'd0);
    check("rstmid_hi", {32'd0, hi0}, 64'd0);
    check("rstmid_lo", {32'd0, lo0}, 64'd0);
    #2;
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("rstmid_no_commit_hi", {32'd0, hi0}, 64'd0);
    check("rstmid_no_commit_lo", {32'd0, lo0}, 64'd0);
    check("rstmid_busy_after", {63'd0, busy0}, 64'd0);

    d_is_mdu = 1'b1;
    run_op(1'b1, 3'd1, 32'h80000000, 32'd4, 1, 32'd2, 32'd0, "p1_multu");
    run_op(1'b1, 3'd5, 32'h55, 32'd0, 0, 32'd2, 32'h55, "p1_mtlo");
    run_op(1'b1, 3'd3, 32'd9, 32'd4, 1, 32'd1, 32'd2, "p1_divu");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
